// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Holds the fetch FSM state encoding and the default reset fetch address.
// Imported by fetch_queue and fq_fifo; no logic of its own.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // issuing requests while credits remain
    FULL  = 2'd1,  // credits exhausted, waiting for a pop or response
    FLUSH = 2'd2   // discarding responses to pre-redirect requests
  } fq_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

endpackage

// File: rtl/fq_fifo.sv
// Purpose: synchronous FIFO storage for fetched {pc, instr} entries, with occupancy count.
// Latency: a push is visible at head_data / count the cycle after it is written.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
// Ports: clk, reset (async, active-high), flush (drops all entries), push/push_data,
//        pop, head_data (oldest entry), count (current occupancy).
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage needs no reset: entries are only observed once count says they are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Purpose: instruction fetch queue; issues sequential word fetches, buffers in-order
//          responses with their pc, and flushes/refetches on redirect.
// Latency: response to instr_valid is 1 cycle; redirect to first new request is 1 cycle
//          (plus draining of stale responses when requests were outstanding).
// Backpressure: credit-based; requests stop once occupancy + outstanding reaches DEPTH
//          or outstanding reaches MAX_OUT, and resume when a pop or response frees a credit.
// Ports: clk, reset (async, active-high); redirect_valid/redirect_pc from the core;
//        mem_req_valid/addr/ready and mem_rsp_valid/data to instruction memory;
//        instr_valid/instr/instr_pc/instr_ready to the core.
// Option: define FETCH_QUEUE_PERF_EN to add the flush_count [15:0] redirect counter port.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [15:0] flush_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAX_L   = CW'(MAX_OUT);

  fq_state_t     state;
  logic [31:0]   fetch_pc;     // next address to request
  logic [31:0]   rsp_pc;       // address of the oldest outstanding request
  logic [CW-1:0] out_cnt;      // requests issued, response not yet seen
  logic [CW-1:0] discard_cnt;  // stale responses still to drop
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_nxt;
  logic [CW-1:0] out_nxt;
  logic [63:0]   head_data;
  logic          credit_ok;
  logic          req_fire;
  logic          push;
  logic          pop;

  function automatic logic has_credit(input logic [CW-1:0] o, input logic [CW-1:0] n);
    return (({1'b0, o} + {1'b0, n}) < DEPTH_L) && (n < MAX_L);
  endfunction

  always_comb begin
    credit_ok     = has_credit(occ, out_cnt);
    // Redirect wins over any request in the same cycle.
    mem_req_valid = !reset && (state == FETCH) && credit_ok && !redirect_valid;
    req_fire      = mem_req_valid && mem_req_ready;
    push          = mem_rsp_valid && (state != FLUSH) && !redirect_valid;
    pop           = instr_valid && instr_ready && !redirect_valid;
    occ_nxt       = redirect_valid ? '0 : (occ + CW'(push) - CW'(pop));
    out_nxt       = out_cnt + CW'(req_fire) - CW'(mem_rsp_valid);
  end

  assign mem_req_addr = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      out_cnt     <= '0;
      discard_cnt <= '0;
    end else begin
      out_cnt <= out_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        // Every request still in flight after this cycle's response is stale.
        discard_cnt <= out_nxt;
        state       <= (out_nxt != '0) ? FLUSH : FETCH;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd1;
        if (push)     rsp_pc   <= rsp_pc + 32'd1;
        if (state == FLUSH) begin
          if (mem_rsp_valid) begin
            discard_cnt <= discard_cnt - CW'(1);
            if (discard_cnt == CW'(1)) begin
              state <= has_credit(occ_nxt, out_nxt) ? FETCH : FULL;
            end
          end
        end else begin
          state <= has_credit(occ_nxt, out_nxt) ? FETCH : FULL;
        end
      end
    end
  end

  fq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({rsp_pc, mem_rsp_data}),
    .pop       (pop),
    .head_data (head_data),
    .count     (occ)
  );

  // Head outputs come only from registered state; zeroed while the queue is empty.
  assign instr_valid = (occ != '0);
  assign instr       = instr_valid ? head_data[31:0]  : 32'h0;
  assign instr_pc    = instr_valid ? head_data[63:32] : 32'h0;

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_count <= 16'h0;
    end else if (redirect_valid && (flush_count != 16'hFFFF)) begin
      flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH=4, MAX_OUT=2, RESET_PC=0) with an
// in-order instruction memory model of configurable latency.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_QUEUE_PERF_EN
  logic [15:0] flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_dat[$];

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0),
    .MAX_OUT  (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .flush_count    (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle();
    logic took;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mdat(pend_addr[0]);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
    end
    #1;
    if (mem_req_valid && mem_req_ready) begin
      pend_addr.push_back(mem_req_addr);
      pend_due.push_back(cyc + lat);
      req_log.push_back(mem_req_addr);
    end
    if (instr_valid && instr_ready) begin
      dlv_pc.push_back(instr_pc);
      dlv_dat.push_back(instr);
    end
    took = mem_rsp_valid;
    @(posedge clk);
    if (took) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    instr_ready    = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    req_log.delete();
    dlv_pc.delete();
    dlv_dat.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    #1;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    instr_ready    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", mem_req_valid); end
    n_checks++; if (mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr got %h want 0", mem_req_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc got %h want 0", instr_pc); end
    apply_reset();
    n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid got %b want 1", mem_req_valid); end
  endtask

  task automatic test_sequential();
    apply_reset();
    lat = 1;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
        n_fail++; $display("FAIL stall_hold valid=%b addr=%h want 1/00000000", mem_req_valid, mem_req_addr);
      end
      cycle();
    end
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    run(20);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (req_log[i] !== 32'(i)) begin n_fail++; $display("FAIL seq_req[%0d] got %h want %h", i, req_log[i], 32'(i)); end
    end
    n_checks++; if (dlv_pc.size() < 10) begin n_fail++; $display("FAIL seq_dlv_count got %0d want >=10", dlv_pc.size()); end
    for (int i = 0; i < dlv_pc.size(); i++) begin
      n_checks++; if (dlv_pc[i] !== 32'(i) || dlv_dat[i] !== mdat(32'(i))) begin
        n_fail++; $display("FAIL seq_dlv[%0d] pc=%h dat=%h want %h/%h", i, dlv_pc[i], dlv_dat[i], 32'(i), mdat(32'(i)));
      end
    end
  endtask

  task automatic test_full();
    apply_reset();
    lat = 1;
    instr_ready = 1'b0;
    run(10);
    n_checks++; if (req_log.size() != 4) begin n_fail++; $display("FAIL full_req_count got %0d want 4", req_log.size()); end
    n_checks++; if (pend_due.size() != 0) begin n_fail++; $display("FAIL full_pending got %0d want 0", pend_due.size()); end
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_req_valid got %b want 0", mem_req_valid); end
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      n_fail++; $display("FAIL full_head valid=%b pc=%h want 1/00000000", instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    run(5);
    n_checks++; if (dlv_pc.size() != 1 || dlv_pc[0] !== 32'h0) begin n_fail++; $display("FAIL full_pop got size %0d want 1 entry pc 0", dlv_pc.size()); end
    n_checks++; if (req_log.size() != 5) begin n_fail++; $display("FAIL full_refill_count got %0d want 5", req_log.size()); end
    n_checks++; if (req_log[req_log.size()-1] !== 32'h4) begin n_fail++; $display("FAIL full_refill_addr got %h want 4", req_log[req_log.size()-1]); end
    n_checks++; if (mem_req_valid !== 1'b0 || instr_pc !== 32'h1) begin
      n_fail++; $display("FAIL full_after_pop valid=%b pc=%h want 0/00000001", mem_req_valid, instr_pc);
    end
    // Redirect while full with nothing outstanding: queue clears, fetch resumes at once.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_head_clear got %b want 0", instr_valid); end
    n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
      n_fail++; $display("FAIL redirect_refetch valid=%b addr=%h want 1/00000100", mem_req_valid, mem_req_addr);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    lat = 3;
    instr_ready = 1'b1;
    run(2);
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_max_out got %b want 0", mem_req_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_req[%0d] got %b want 0", i, mem_req_valid); end
      cycle();
    end
    #1;
    n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40) begin
      n_fail++; $display("FAIL flush_refetch valid=%b addr=%h want 1/00000040", mem_req_valid, mem_req_addr);
    end
    run(10);
    n_checks++; if (dlv_pc.size() < 2) begin n_fail++; $display("FAIL flush_dlv_count got %0d want >=2", dlv_pc.size()); end
    else begin
      n_checks++; if (dlv_pc[0] !== 32'h40 || dlv_dat[0] !== mdat(32'h40)) begin
        n_fail++; $display("FAIL flush_first pc=%h dat=%h want 00000040/%h", dlv_pc[0], dlv_dat[0], mdat(32'h40));
      end
      n_checks++; if (dlv_pc[1] !== 32'h41) begin n_fail++; $display("FAIL flush_second got %h want 00000041", dlv_pc[1]); end
    end
  endtask

  task automatic test_double_redirect();
    int hits;
    apply_reset();
    lat = 3;
    instr_ready = 1'b1;
    run(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cycle();
    // Second redirect lands in the same cycle as the first stale response.
    redirect_pc    = 32'h80;
    cycle();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL dbl_flush_no_req got %b want 0", mem_req_valid); end
    cycle();
    #1;
    n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h80) begin
      n_fail++; $display("FAIL dbl_refetch valid=%b addr=%h want 1/00000080", mem_req_valid, mem_req_addr);
    end
    run(10);
    hits = 0;
    foreach (dlv_pc[i]) if (dlv_pc[i] == 32'h40) hits++;
    foreach (req_log[i]) if (req_log[i] == 32'h40) hits++;
    n_checks++; if (hits != 0) begin n_fail++; $display("FAIL dbl_stale_40 got %0d occurrences want 0", hits); end
    n_checks++; if (dlv_pc.size() == 0 || dlv_pc[0] !== 32'h80) begin
      n_fail++; $display("FAIL dbl_first got size %0d want first pc 00000080", dlv_pc.size());
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    lat = 1;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    cycle();
    redirect_valid = 1'b0;
    run(8);
    n_checks++; if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFF || req_log[1] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_req size=%0d want FFFFFFFF then 00000000", req_log.size());
    end
    n_checks++; if (dlv_pc.size() < 2 || dlv_pc[0] !== 32'hFFFF_FFFF || dlv_pc[1] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_dlv size=%0d want FFFFFFFF then 00000000", dlv_pc.size());
    end
  endtask

`ifdef FETCH_QUEUE_PERF_EN
  task automatic test_perf();
    apply_reset();
    lat = 1;
    instr_ready = 1'b1;
    n_checks++; if (flush_count !== 16'd0) begin n_fail++; $display("FAIL perf_reset got %0d want 0", flush_count); end
    for (int i = 0; i < 3; i++) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200 + 32'(i * 16);
      cycle();
      redirect_valid = 1'b0;
      run(3);
    end
    n_checks++; if (flush_count !== 16'd3) begin n_fail++; $display("FAIL perf_count got %0d want 3", flush_count); end
    apply_reset();
    n_checks++; if (flush_count !== 16'd0) begin n_fail++; $display("FAIL perf_rereset got %0d want 0", flush_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_flush();
    test_double_redirect();
    test_wrap();
`ifdef FETCH_QUEUE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-003 Parameter MAX_OUT, default 2: maximum outstanding memory requests; 1..DEPTH.
REQ-004 clk  in  1  clock; all state on posedge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 redirect_valid  in  1  core branch/jump taken; flush and refetch.
REQ-007 redirect_pc  in  32  new word address, sampled when redirect_valid=1.
REQ-008 mem_req_valid  out  1  fetch request to instruction memory.
REQ-009 mem_req_addr  out  32  word address of the request.
REQ-010 mem_req_ready  in  1  memory accepts the request this cycle.
REQ-011 mem_rsp_valid  in  1  instruction word returned, in request order, latency >= 1 cycle.
REQ-012 mem_rsp_data  in  32  returned instruction.
REQ-013 instr_valid  out  1  queue head holds a valid instruction.
REQ-014 instr  out  32  head instruction.
REQ-015 instr_pc  out  32  word address of the head instruction.
REQ-016 instr_ready  in  1  core consumes the head this cycle.

Function
REQ-017 Addressing is word-granular: sequential fetch address increments by 1, mod 2^32.
REQ-018 A request transfers when mem_req_valid && mem_req_ready; mem_req_addr holds stable while valid and not ready.
REQ-019 Credit rule: mem_req_valid=1 only if occupancy + outstanding < DEPTH and outstanding < MAX_OUT.
REQ-020 A response is written at the tail with its request address; a response is never dropped in FETCH state.
REQ-021 The head pops when instr_valid && instr_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-022 The head is registered; instr, instr_pc and instr_valid have no combinational path from any input.
REQ-023 FSM states: FETCH (issuing), FULL (credits exhausted, no requests), FLUSH (discarding stale responses).
REQ-024 FETCH->FULL when credits reach zero; FULL->FETCH when a pop or response frees a credit.
REQ-025 On redirect_valid: the queue empties next cycle; the fetch address becomes redirect_pc; discard count becomes outstanding minus any response arriving that cycle.
REQ-026 After a redirect the block enters FLUSH if discard count > 0, else FETCH.
REQ-027 In FLUSH, each response decrements discard count and is not written; no requests issue; FLUSH->FETCH when the count reaches 0.
REQ-028 A redirect during FLUSH updates the fetch address; discard count becomes the current outstanding count.
REQ-029 A redirect has priority over a simultaneous pop, push or request; no request issues in the redirect cycle.
REQ-030 instr_valid is forced to 0 in the cycle after a redirect.

Reset
REQ-031 On reset: state FETCH, fetch address RESET_PC, occupancy 0, outstanding 0, discard count 0.
REQ-032 Output reset values: mem_req_valid=0, mem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-033 Reset mid-operation abandons in-flight requests; memory is reset together with this block.
REQ-034 mem_req_valid first asserts in the first cycle after reset deasserts.

Configuration
REQ-035 With FETCH_QUEUE_PERF_EN defined: add output flush_count [15:0]; it increments on each redirect_valid cycle, saturates at 16'hFFFF, and resets to 0.
REQ-036 Without FETCH_QUEUE_PERF_EN: no port is added and no counter logic exists.

Structure
REQ-037 A shared package fetch_pkg holds the FSM state enum (FETCH, FULL, FLUSH) and the constant RESET_PC_DEFAULT.
REQ-038 The sub-module fq_fifo (synchronous FIFO, DEPTH x 64 bits {pc, instr}, with count output) holds the storage.
REQ-039 Counters are $clog2(DEPTH)+1 bits wide; pointers wrap mod DEPTH.

Verification
REQ-040 Reset then 1-cycle memory with instr_ready=1 -> requests at addresses 0,1,2,...; instr_pc sequence 0,1,2,... with no gaps.
REQ-041 instr_ready=0 with DEPTH=4 -> exactly 4 responses accepted; mem_req_valid=0 (state FULL); one pop -> one new request.
REQ-042 Memory latency 3, MAX_OUT=2, redirect to 32'h40 with 2 outstanding -> 2 responses discarded; first instr_pc delivered is 32'h40.
REQ-043 A second redirect to 32'h80 during FLUSH -> no instruction from 32'h40 is delivered; the next delivered instr_pc is 32'h80.
REQ-044 Fetch address 32'hFFFFFFFF -> next request address is 32'h0.
REQ-045 With FETCH_QUEUE_PERF_EN, 3 redirects -> flush_count=3; reset -> flush_count=0.
